shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 2, meaning the maximum bit positions shifted per BUSY cycle (legal 1..16).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a request is present.
REQ-005 The block SHALL have port in_ready, output, 1, meaning a request is accepted this cycle.
REQ-006 The block SHALL have port op, input, 2, meaning 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
REQ-007 The block SHALL have port data, input, 32, the operand.
REQ-008 The block SHALL have port shamt, input, 5, the shift amount.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is held.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port result, output, 32, the shifted value.
REQ-012 The block SHALL have port err, output, 1, meaning an illegal op, qualified by out_valid.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL equal (state==IDLE), combinationally from the state register only.
REQ-015 On a clock edge with IDLE and in_valid, the block SHALL latch data, op and the remaining count (=shamt).
  - remaining != 0: go to BUSY.
  - remaining == 0: go to DONE.
REQ-016 Each BUSY cycle SHALL shift the working register by k=min(remaining,STEP) and decrement remaining by k.
  - SLL zero-fills from the LSB.
  - SRL zero-fills from the MSB.
  - SRA replicates bit 31.
  - ROTR rotates bits out of the LSB into the MSB.
REQ-017 BUSY SHALL go to DONE on the edge where remaining reaches 0; the number of BUSY cycles is ceil(shamt/STEP).
REQ-018 In DONE, out_valid SHALL be 1 and result SHALL equal the working register.
REQ-019 result and err SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-020 On a DONE edge with out_ready=1, the FSM SHALL return to IDLE; there is no DONE-to-BUSY bypass, so back-to-back throughput is one request per ceil(shamt/STEP)+2 cycles.
REQ-021 While not in IDLE, in_valid SHALL be ignored and nothing SHALL be latched.
REQ-022 Changes to op, data or shamt after acceptance SHALL have no effect on the operation in progress.
REQ-023 result SHALL never be an intermediate value while out_valid is 1.

Reset
REQ-024 Asserting rst_n=0, at any time including mid-BUSY, SHALL immediately force the following:
  - state=IDLE, in_ready=1.
  - out_valid=0, err=0.
  - result=0x0000_0000, remaining=0.
REQ-025 The first request accepted after rst_n deasserts SHALL behave as if no earlier operation existed.

Configuration
REQ-026 With macro SHIFT_ROTATE_EN defined, op=11 SHALL perform ROTR per REQ-016 and err SHALL be 0.
REQ-027 Without SHIFT_ROTATE_EN, op=11 SHALL be accepted and SHALL go to DONE the cycle after acceptance, regardless of shamt, with result=data and err=1.
  - No rotate logic SHALL be synthesized in this case.

Structure
REQ-028 A shared package shift_pkg SHALL hold:
  - the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROTR);
  - the FSM state encoding;
  - the data-width constant 32.
REQ-029 One sub-module, shift_step, SHALL exist: the combinational single-step shifter (inputs: value, op, k; output: shifted value), instantiated once by the FSM.

Verification
REQ-030 The bench SHALL cover these scenarios (STEP=2, cycle counts from the accept edge):
  - SLL data=0x0000_0001, shamt=2: out_valid 2 cycles after accept, result=0x0000_0004, err=0.
  - SRA data=0x8000_0000, shamt=31: 16 BUSY cycles, out_valid after 17 cycles, result=0xFFFF_FFFF. The same with SRL gives result=0x0000_0001.
  - shamt=0, data=0xDEAD_BEEF, SLL: out_valid the next cycle, result=0xDEAD_BEEF.
  - SLL data=0x1, shamt=3, out_ready held 0 for 5 cycles: result=0x8 stable, in_ready=0, a competing in_valid ignored. After out_ready=1: IDLE the next cycle.
  - rst_n pulsed low in the 3rd BUSY cycle of a shamt=20 op: out_valid=0 and in_ready=1 immediately. A fresh SLL data=0x1, shamt=1 then yields 0x2.
  - op=11, data=0x0000_0001, shamt=1:
    - with SHIFT_ROTATE_EN: result=0x8000_0000, err=0;
    - without it: result=0x0000_0001, err=1, one cycle after accept.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: data width, op codes and FSM states.
// Used by shift_step and shift_sequencer (optional rotate via SHIFT_ROTATE_EN).
package shift_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k positions according to op.
// Rotate-right hardware exists only when SHIFT_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        op,
    input  logic [4:0]        k,
    output logic [DATA_W-1:0] shifted
);

    always_comb begin
        shifted = value;
        case (op)
            OP_SLL:  shifted = value << k;
            OP_SRL:  shifted = value >> k;
            OP_SRA:  shifted = DATA_W'($signed(value) >>> k);
`ifdef SHIFT_ROTATE_EN
            // a 6-bit left amount of 32 (k=0) clears the wrapped half, leaving value unchanged
            OP_ROTR: shifted = (value >> k) | (value << (6'd32 - {1'b0, k}));
`endif
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: IDLE accepts a request, BUSY shifts up to STEP bits per cycle,
// DONE holds the result until taken. Define SHIFT_ROTATE_EN to enable op=11 (ROTR).
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data,
    input  logic [4:0]        shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    localparam logic [4:0] STEP_K = 5'(STEP);

    logic [1:0]        state;
    logic [DATA_W-1:0] work;
    logic [4:0]        remaining;
    logic [1:0]        op_q;
    logic              err_q;
    logic [4:0]        k;
    logic [DATA_W-1:0] stepped;

    assign k = (remaining < STEP_K) ? remaining : STEP_K;

    shift_step u_step (
        .value   (work),
        .op      (op_q),
        .k       (k),
        .shifted (stepped)
    );

    // Only IDLE latches inputs, so late changes on op/data/shamt cannot disturb an operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            remaining <= '0;
            op_q      <= OP_SLL;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work      <= data;
                        op_q      <= op;
                        remaining <= shamt;
`ifdef SHIFT_ROTATE_EN
                        err_q     <= 1'b0;
                        state     <= (shamt == 5'd0) ? ST_DONE : ST_BUSY;
`else
                        if (op == OP_ROTR) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= (shamt == 5'd0) ? ST_DONE : ST_BUSY;
                        end
`endif
                    end
                end
                ST_BUSY: begin
                    work      <= stepped;
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = work;
    assign err       = err_q & out_valid;

endmodule
